// File: rtl/noc_flit_pkg.sv
// noc_flit_pkg: flit field layout, credit-return type and field helpers shared by the injector.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif
package noc_flit_pkg;
  localparam int FLIT_WIDTH = `FLIT_WIDTH;
  localparam int VC_BITS = `VC_BITS;
  localparam int NUM_VCS = 2 ** VC_BITS;
  localparam int VALID_BIT = FLIT_WIDTH - 1;
  localparam int TAIL_BIT = FLIT_WIDTH - 2;
  localparam int DST_HI = FLIT_WIDTH - 3;
  localparam int DST_LO = FLIT_WIDTH - 4;
  localparam int VC_HI = FLIT_WIDTH - 5;
  localparam int VC_LO = VC_HI - VC_BITS + 1;
  typedef logic [FLIT_WIDTH-1:0] flit_t;
  typedef struct packed {
    logic valid;
    logic [VC_BITS-1:0] vc;
  } credit_t;
  function automatic logic [VC_BITS-1:0] flit_vc(input flit_t f);
    return f[VC_HI:VC_LO];
  endfunction
endpackage

// File: rtl/flit_sync_fifo.sv
// flit_sync_fifo: synchronous FIFO with full/empty flags and asynchronous active-high reset.
module flit_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] pushData,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty = wrPtr == rdPtr;
    full = wrPtr == {~rdPtr[AW], rdPtr[AW-1:0]};
    popData = mem[rdPtr[AW-1:0]];
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push && !full) wrPtr <= wrPtr + 1'b1;
      if (pop && !empty) rdPtr <= rdPtr + 1'b1;
    end
  always_ff @(posedge CLK)
    if (push && !full) mem[wrPtr[AW-1:0]] <= pushData;
endmodule

// File: rtl/flit_credit_injector.sv
// flit_credit_injector: buffers bridge flits and forwards them in order under per-VC credit control.
// Define INJECTOR_STATS_EN to build the sent-flit and stall-cycle statistics counters.
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef VC_BITS
`define VC_BITS 1
`endif
module flit_credit_injector #(
  parameter int FLIT_WIDTH = `FLIT_WIDTH,
  parameter int VC_BITS = `VC_BITS,
  parameter int NUM_VCS = 2 ** VC_BITS,
  parameter int CREDITS_PER_VC = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [FLIT_WIDTH-1:0] put_flit,
  input  logic                  put_flit_valid,
  output logic                  put_flit_ready,
  output logic [FLIT_WIDTH-1:0] send_ports_putFlit_flit_in,
  output logic                  EN_send_ports_putFlit,
  input  logic [VC_BITS:0]      send_ports_getCredits,
  output logic                  EN_send_ports_getCredits,
  output logic                  credit_overflow,
  output logic [31:0]           stat_flits_sent,
  output logic [31:0]           stat_stall_cycles
);
  import noc_flit_pkg::*;
  localparam int CW = $clog2(CREDITS_PER_VC + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDITS_PER_VC);
  flit_t headFlit;
  logic fifoFull, fifoEmpty, headReady, overflowHit;
  logic [VC_BITS-1:0] headVc;
  credit_t creditRet;
  logic [NUM_VCS-1:0] retHit, useHit;
  logic [CW-1:0] credit [NUM_VCS];
  logic [CW-1:0] creditNext [NUM_VCS];

  flit_sync_fifo #(.WIDTH(FLIT_WIDTH), .DEPTH(FIFO_DEPTH)) fifo (
    .CLK(CLK),
    .RST(RST),
    .pushData({1'b1, put_flit[FLIT_WIDTH-2:0]}),
    .push(put_flit_valid && put_flit_ready),
    .pop(EN_send_ports_putFlit),
    .popData(headFlit),
    .full(fifoFull),
    .empty(fifoEmpty)
  );

  // A return that meets a send on the same VC nets out; a return into a full counter is clamped and flagged.
  always_comb begin
    creditRet = send_ports_getCredits;
    headVc = flit_vc(headFlit);
    headReady = !fifoEmpty && credit[headVc] != '0;
    put_flit_ready = !RST && !fifoFull;
    EN_send_ports_putFlit = !RST && headReady;
    send_ports_putFlit_flit_in = EN_send_ports_putFlit ? headFlit : '0;
    EN_send_ports_getCredits = !RST;
    retHit = creditRet.valid ? NUM_VCS'(1) << creditRet.vc : '0;
    useHit = EN_send_ports_putFlit ? NUM_VCS'(1) << headVc : '0;
    overflowHit = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      creditNext[v] = (retHit[v] && !useHit[v]) ? (credit[v] == CREDIT_MAX ? credit[v] : credit[v] + 1'b1)
                    : (useHit[v] && !retHit[v]) ? credit[v] - 1'b1 : credit[v];
      overflowHit = overflowHit || (retHit[v] && !useHit[v] && credit[v] == CREDIT_MAX);
    end
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      for (int v = 0; v < NUM_VCS; v++) credit[v] <= CREDIT_MAX;
      credit_overflow <= 1'b0;
    end else begin
      credit <= creditNext;
      credit_overflow <= credit_overflow || overflowHit;
    end

`ifdef INJECTOR_STATS_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      stat_flits_sent <= '0;
      stat_stall_cycles <= '0;
    end else begin
      stat_flits_sent <= stat_flits_sent + 32'(EN_send_ports_putFlit);
      stat_stall_cycles <= stat_stall_cycles + 32'(!fifoEmpty && !headReady);
    end
`else
  assign stat_flits_sent = '0;
  assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_flit_credit_injector.sv
// tb_flit_credit_injector: directed scoreboard bench for flit_credit_injector.
module tb_flit_credit_injector;
  import noc_flit_pkg::*;
  localparam int FW = FLIT_WIDTH;
  localparam int VB = VC_BITS;
  localparam int DEPTH = 4;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  flit_t put_flit = '0;
  logic put_flit_valid = 1'b0;
  logic put_flit_ready;
  flit_t flitIn;
  logic enPut, enGet, credit_overflow;
  logic [VB:0] getCredits = '0;
  logic [31:0] statSent, statStall;
  int compared = 0;
  int mismatched = 0;
  int sentCount = 0;
  flit_t expQ[$];

  always #5 CLK = ~CLK;

  flit_credit_injector #(.FLIT_WIDTH(FW), .VC_BITS(VB), .CREDITS_PER_VC(4), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK),
    .RST(RST),
    .put_flit(put_flit),
    .put_flit_valid(put_flit_valid),
    .put_flit_ready(put_flit_ready),
    .send_ports_putFlit_flit_in(flitIn),
    .EN_send_ports_putFlit(enPut),
    .send_ports_getCredits(getCredits),
    .EN_send_ports_getCredits(enGet),
    .credit_overflow(credit_overflow),
    .stat_flits_sent(statSent),
    .stat_stall_cycles(statStall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic flit_t mk(input logic vld, input logic [VB-1:0] vc, input int pl);
    flit_t f = '0;
    f[FW-1] = vld;
    f[FW-3:FW-4] = 2'b10;
    f[FW-5 -: VB] = vc;
    f[FW-5-VB:0] = pl[FW-5-VB:0];
    return f;
  endfunction

  function automatic flit_t fwd(input flit_t f);
    return {1'b1, f[FW-2:0]};
  endfunction

  // Scoreboard pop: every sent flit must be the oldest accepted one.
  always @(negedge CLK)
    if (!RST && enPut) begin
      sentCount++;
      check("send_order", flitIn, expQ.size() != 0 ? expQ.pop_front() : 'x);
    end

  task automatic cyc(input logic pv, input flit_t f, input logic rv, input logic [VB-1:0] rvc);
    put_flit_valid = pv;
    put_flit = f;
    getCredits = {rv, rvc};
    @(negedge CLK);
    if (put_flit_valid && put_flit_ready) expQ.push_back(fwd(f));
    @(posedge CLK);
    #1;
    put_flit_valid = 1'b0;
    getCredits = '0;
  endtask

  task automatic idle();
    cyc(1'b0, '0, 1'b0, '0);
  endtask

  task automatic doReset();
    RST = 1'b1;
    #1;
    check("rst_ready", put_flit_ready, 0);
    check("rst_en_put", enPut, 0);
    check("rst_flit_in", flitIn, 0);
    check("rst_en_get", enGet, 0);
    check("rst_overflow", credit_overflow, 0);
    check("rst_stat_sent", statSent, 0);
    check("rst_stat_stall", statStall, 0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    expQ.delete();
    #1;
    check("rel_ready", put_flit_ready, 1);
    check("rel_en_get", enGet, 1);
    check("rel_en_put", enPut, 0);
  endtask

  initial begin
    int s0, occ, cred, pushed, stalls, sends;
    logic expEn, pv, rv;
    logic [2:0] pipe;
    flit_t f;
    doReset();
    // Credit exhaustion on VC0, then fill the FIFO behind a blocked head.
    s0 = sentCount;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, mk(1'b1, '0, i + 1), 1'b0, '0);
      check("t1_send", enPut, 1);
    end
    idle();
    check("t1_drained", enPut, 0);
    check("t1_count", sentCount - s0, 4);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, mk(1'b1, '0, 16 + i), 1'b0, '0);
      check("t1_blocked", enPut, 0);
      check("t1_ready", put_flit_ready, i < 3);
    end
    check("t1_count_hold", sentCount - s0, 4);
    cyc(1'b0, '0, 1'b1, '0);
    check("t1_full_pop_ready", put_flit_ready, 0);
    check("t1_full_pop_en", enPut, 1);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, '0);
    idle();
    idle();
    check("t1_drain_count", sentCount - s0, 8);
    check("t1_drain_ready", put_flit_ready, 1);
    check("t1_drain_en", enPut, 0);
    // Valid bit forced on accept; no bypass of an empty FIFO.
    f = mk(1'b0, 1, 'h1234);
    put_flit = f;
    put_flit_valid = 1'b1;
    #1;
    check("t2_no_bypass", enPut, 0);
    cyc(1'b1, f, 1'b0, '0);
    check("t2_en", enPut, 1);
    check("t2_flit", flitIn, {1'b1, f[FW-2:0]});
    idle();
    // Head-of-line blocking behind a credit-starved VC0 flit.
    cyc(1'b1, mk(1'b1, 0, 'hA0), 1'b0, '0);
    check("t3_hol_a", enPut, 0);
    cyc(1'b1, mk(1'b1, 1, 'hB0), 1'b0, '0);
    check("t3_hol_b", enPut, 0);
    idle();
    check("t3_hol_hold", enPut, 0);
    cyc(1'b0, '0, 1'b1, 0);
    check("t3_vc0_en", enPut, 1);
    check("t3_vc0_flit", flitIn, fwd(mk(1'b1, 0, 'hA0)));
    idle();
    check("t3_vc1_en", enPut, 1);
    check("t3_vc1_flit", flitIn, fwd(mk(1'b1, 1, 'hB0)));
    idle();
    check("t3_done", enPut, 0);
    // Return on a starved VC is usable only in the following cycle.
    cyc(1'b1, mk(1'b1, 1, 'hC1), 1'b0, '0);
    cyc(1'b1, mk(1'b1, 1, 'hC2), 1'b0, '0);
    idle();
    idle();
    check("t4_vc1_drained", enPut, 0);
    cyc(1'b1, mk(1'b1, 1, 'hC3), 1'b0, '0);
    check("t4_blocked", enPut, 0);
    cyc(1'b0, '0, 1'b1, 1);
    check("t4_en", enPut, 1);
    check("t4_flit", flitIn, fwd(mk(1'b1, 1, 'hC3)));
    idle();
    check("t4_after", enPut, 0);
    cyc(1'b1, mk(1'b1, 1, 'hC4), 1'b0, '0);
    idle();
    check("t4_credit_zero", enPut, 0);
    cyc(1'b0, '0, 1'b1, 1);
    check("t4_release", enPut, 1);
    idle();
    // Overflow: clamp at the maximum and keep the flag until reset.
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, 0);
    check("t5_no_ovf", credit_overflow, 0);
    cyc(1'b0, '0, 1'b1, 0);
    check("t5_ovf", credit_overflow, 1);
    s0 = sentCount;
    for (int i = 0; i < 5; i++) cyc(1'b1, mk(1'b1, 0, 'h50 + i), 1'b0, '0);
    idle();
    idle();
    check("t5_clamped_sends", sentCount - s0, 4);
    check("t5_blocked", enPut, 0);
    check("t5_ovf_sticky", credit_overflow, 1);
    doReset();
    // Streaming with delayed credit returns, then a return blackout to create stalls.
    occ = 0;
    cred = 4;
    pushed = 0;
    stalls = 0;
    sends = 0;
    pipe = '0;
    for (int c = 0; c < 60; c++) begin
      expEn = occ > 0 && cred > 0;
      check("t6_en", enPut, expEn);
      if (occ > 0 && cred == 0) stalls++;
      pv = pushed < (c < 40 ? 10 : 15) && occ < DEPTH;
      rv = c < 40 && pipe[2];
      sends += int'(expEn);
      occ = occ + int'(pv) - int'(expEn);
      cred = cred + int'(rv) - int'(expEn);
      pushed += int'(pv);
      pipe = {pipe[1:0], expEn};
      cyc(pv, mk(1'b1, 0, pushed), rv, 0);
    end
`ifdef INJECTOR_STATS_EN
    check("t6_stat_sent", statSent, sends);
    check("t6_stat_stall", statStall, stalls);
`else
    check("t6_stat_sent_tied", statSent, 0);
    check("t6_stat_stall_tied", statStall, 0);
`endif
    doReset();
    cyc(1'b1, mk(1'b1, 0, 'h77), 1'b0, '0);
    check("t6_post_reset_en", enPut, 1);
    idle();
    check("t6_post_reset_idle", enPut, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/flit_credit_injector.md
Name: flit_credit_injector

Overview:
Credit-tracked injection stage between an AXI4-Stream master bridge's flit output (put_flit valid/ready) and one network send port (putFlit/getCredits).
Buffers flits in a small FIFO and keeps one credit counter per VC, mirroring the router input buffer.
Forwards a head flit only when its VC holds a credit, in strict order.
One instance per master-side endpoint.

Parameters:
FLIT_WIDTH, `FLIT_WIDTH, total flit width; bit FW-1 valid, FW-2 tail, [FW-3:FW-4] dst, [FW-5 -: VC_BITS] vc, remainder payload
VC_BITS, `VC_BITS, VC index width
NUM_VCS, 2**VC_BITS, number of virtual channels
CREDITS_PER_VC, 4, router input buffer depth per VC = initial credit count
FIFO_DEPTH, 4, local flit buffer depth (power of two, >=2)

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  reset; asynchronous, active-high
put_flit  in  FLIT_WIDTH  flit from bridge
put_flit_valid  in  1  flit present
put_flit_ready  out  1  FIFO not full
send_ports_putFlit_flit_in  out  FLIT_WIDTH  flit to network
EN_send_ports_putFlit  out  1  one-cycle send strobe
send_ports_getCredits  in  VC_BITS+1  [VC_BITS] credit valid, [VC_BITS-1:0] vc
EN_send_ports_getCredits  out  1  credit poll enable
credit_overflow  out  1  sticky error flag
stat_flits_sent  out  32  see Optional Feature
stat_stall_cycles  out  32  see Optional Feature

Behaviour:
- Reset (async assert, sync release): FIFO empty; credit[v]=CREDITS_PER_VC for all v; credit_overflow=0; stats=0. During reset: put_flit_ready=0, EN_send_ports_putFlit=0, flit_in=0, EN_send_ports_getCredits=0.
- Out of reset: EN_send_ports_getCredits held 1 constantly.
- Accept: put_flit_ready = !full.
  - Accept on valid&&ready. Stored flit has bit FW-1 forced to 1.
  - Accept while full is impossible by ready.
- Send (combinational from FIFO head and credit registers): EN_send_ports_putFlit = !empty && credit[head_vc]!=0. flit_in = head when EN, else 0.
  - Pop on EN.
  - Flit accepted at edge N is sent no earlier than cycle N+1 (no bypass of an empty FIFO).
- Order: strict FIFO. A head blocked on VC a also blocks flits for VC b (head-of-line blocking is intended).
- Simultaneous push and pop when full: allowed. Pop frees the slot at the same edge, but ready is still 0 that cycle (no combinational ready-on-pop).
- Credits: counter width $clog2(CREDITS_PER_VC+1).
  - Per edge: credit[v] += (ret_valid && ret_vc==v) − (EN && head_vc==v).
  - Simultaneous return and consume on the same VC: net unchanged.
  - A credit returned in cycle N is usable in cycle N+1.
- Overflow: a return that would push credit[v] above CREDITS_PER_VC is clamped at CREDITS_PER_VC and sets credit_overflow. It stays set until reset.
- Underflow cannot occur, since a send requires a nonzero credit.
- Reset mid-packet: FIFO contents discarded, credits restored to full. The network is expected to be reset together with this block.

Optional Feature:
INJECTOR_STATS_EN.
- Defined: stat_flits_sent increments on each EN_send_ports_putFlit. stat_stall_cycles increments each cycle with !empty && credit[head_vc]==0. Both wrap modulo 2^32 and clear on reset.
- Undefined: no counter logic; both ports tied 0.

Decomposition:
- Package noc_flit_pkg: flit field bit positions (VALID_BIT, TAIL_BIT, DST_HI/LO, VC_HI/LO); typedefs flit_t and credit_t {valid, vc}; helper function flit_vc(flit_t).
- One sub-module, flit_sync_fifo: parameterised synchronous FIFO with full/empty flags and async active-high reset. Widths FLIT_WIDTH and FIFO_DEPTH.

Test Plan:
1. Reset, then push 4 flits on VC0 with no credit returns: exactly 4 sends on cycles 1–4 after the first push, in order; credit[0]=0. A 5th flit sits at head, EN stays 0, ready stays 1 until the FIFO holds 4.
2. Flit with valid bit 0, payload 0x1234, vc=1: sent one cycle later with bit FW-1=1 and identical remaining bits.
3. Drain VC0 credits, queue one VC0 flit then one VC1 flit: neither sent (HOL). Return a VC0 credit in cycle N: VC0 flit sent N+1, VC1 flit sent N+2.
4. credit[1]=0 with a VC1 flit at head, credit return vc=1 in the same cycle: no send that cycle, send next cycle, credit[1] returns to 0.
5. Credit return for vc=0 while credit[0]=CREDITS_PER_VC: credit_overflow=1 next cycle, counter stays 4, flag remains after further traffic until RST.
6. With INJECTOR_STATS_EN: 10 flits on VC0 with 3-cycle credit return latency gives stat_flits_sent=10 and stat_stall_cycles equal to the bench-counted stall cycles. Assert RST mid-stream: all outputs reset immediately, without waiting for a clock edge.
